mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single slow off-chip memory port between the I-cache miss path and the D-cache miss/write-back path.
- Sits below both caches.
- Grants one whole-line transaction at a time, holds the memory command stable until `mem_ready`, then returns the line to the winner with a one-cycle ready pulse.
- Round-robin on simultaneous requests, so neither cache starves the other. This matters because compressed fetch makes I-cache misses bursty.

Parameters:
ADDR_W, 28, line address width (word address >> 2)
DATA_W, 128, line width in bits

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  reset; synchronous, active-low
i_read  in  1  I-cache line read request, held until i_ready
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  DATA_W  returned I-line, registered
i_ready  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, held until d_ready
d_write  in  1  D-cache line write request, held until d_ready
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  DATA_W  D-cache write line
d_rdata  out  DATA_W  returned D-line, registered
d_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  memory read command, registered
mem_write  out  1  memory write command, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data, valid when mem_ready
mem_ready  in  1  memory completion, one or more cycles high

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-low. When `rst`=0 at a posedge, every register clears:
  - state=IDLE
  - `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0
  - `i_rdata`=`d_rdata`=0, `i_ready`=`d_ready`=0
  - last_grant=D, so the first tie goes to I
  - Reset mid-transaction abandons it; no ready pulse is issued.
- Request definitions: `ireq`=`i_read`; `dreq`=`d_read` | `d_write`. If `d_read` and `d_write` are both 1, the transaction is a write.
- State machine (IDLE, I_BUSY, D_BUSY, DONE):
  - IDLE, no request → stay.
  - IDLE, only `ireq` → I_BUSY. Load `mem_addr`=`i_addr`, `mem_read`=1, `mem_write`=0; last_grant=I.
  - IDLE, only `dreq` → D_BUSY. Load `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`, `mem_write`=`d_write`, `mem_read`=!`d_write`; last_grant=D.
  - IDLE, both → grant the side that is not last_grant.
  - I_BUSY/D_BUSY: `mem_*` hold constant. On `mem_ready`=1 at a posedge → DONE:
    - `mem_read`/`mem_write` clear.
    - For a read, the winner's rdata register captures `mem_rdata`.
    - The winner's ready goes to 1.
    - `d_rdata` is unchanged on a write.
  - DONE: exactly one cycle with the winner's ready=1; no new grant is evaluated. Next posedge → IDLE, ready clears. This swallows the still-high request of the finishing cache.
- Latency:
  - Request high in IDLE at edge N → `mem_read`/`mem_write`=1 after edge N.
  - `mem_ready` sampled at edge K → ready high from K to K+1.
  - Earliest next grant at edge K+2.
- Boundary conditions:
  - `mem_ready` in IDLE/DONE is ignored.
  - `mem_ready` held high for several cycles completes only one transaction.
  - A request dropped mid-transaction still completes and pulses ready.
  - Address/data changes by a requester after grant are ignored.
  - `i_ready` and `d_ready` are never both 1.
  - At most one of `mem_read`/`mem_write` is 1.
  - rdata registers hold their value until the next completion for that side.

Test Plan:
- Reset then `i_read`=1, `i_addr`=28'h0000010, `mem_ready` after 4 cycles with `mem_rdata`=128'hA5…A5 → `mem_read`=1/`mem_addr`=0x10 for 4 cycles; `i_ready` one cycle; `i_rdata`=A5…A5; `d_ready` stays 0.
- `d_write`=1, `d_addr`=0x20, `d_wdata`=128'h1234 → `mem_write`=1, `mem_wdata`=0x1234; `d_ready` pulse; `d_rdata` unchanged; `mem_read` never 1.
- `i_read` and `d_read` both held from reset → grants alternate I, D, I, D; each ready pulses once per grant; no back-to-back same-side grant while the other waits.
- Requester holds request through DONE → no duplicate transaction; `mem_read` stays 0 during DONE; `mem_read` rises for a new grant only once the request is freshly seen in IDLE.
- `rst`=0 asserted while in D_BUSY → next edge `mem_write`=0, state IDLE, `d_ready` never pulses; after release, a tie grants I first.
- `mem_ready` held high 3 cycles and pulsed in IDLE → exactly one completion; no spurious ready.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals of the shared memory-port arbiter.
// The slave modport is the arbiter's view and the master modport is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving the I-cache and D-cache whole-line access to one slow memory port.
// Each transaction finishes with a one-cycle DONE state, which discards the finishing cache's still-held request.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic              last_i_q, last_i_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;

  logic ireq, dreq, grant_i, grant_d;

  // On a tie, the grant goes to the side that did not win last time.
  assign ireq    = bus.i_read;
  assign dreq    = bus.d_read | bus.d_write;
  assign grant_i = ireq & (~dreq | ~last_i_q);
  assign grant_d = dreq & ~grant_i;

  always_comb begin
    state_d     = state_q;
    last_i_d    = last_i_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d     = I_BUSY;
          mem_addr_d  = bus.i_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          last_i_d    = 1'b1;
        end else if (grant_d) begin
          state_d     = D_BUSY;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_write_d = bus.d_write;
          mem_read_d  = ~bus.d_write;
          last_i_d    = 1'b0;
        end
      end
      I_BUSY: begin
        if (bus.mem_ready) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_rdata_d   = bus.mem_rdata;
          i_ready_d   = 1'b1;
        end
      end
      D_BUSY: begin
        if (bus.mem_ready) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) d_rdata_d = bus.mem_rdata;
          d_ready_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_i_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_i_q    <= last_i_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: covers the single-side read and write, round-robin alternation,
// reset during a transaction, and stray or held mem_ready.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] pat_a5;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    pat_a5 = {16{8'hA5}};
    rst = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    tick(); tick();
    check("rst_mem_read",  128'(bus.mem_read),  128'(0));
    check("rst_mem_write", 128'(bus.mem_write), 128'(0));
    check("rst_mem_addr",  128'(bus.mem_addr),  128'(0));
    check("rst_mem_wdata", bus.mem_wdata,       128'(0));
    check("rst_i_rdata",   bus.i_rdata,         128'(0));
    check("rst_d_rdata",   bus.d_rdata,         128'(0));
    check("rst_i_ready",   128'(bus.i_ready),   128'(0));
    check("rst_d_ready",   128'(bus.d_ready),   128'(0));
    rst = 1'b1;

    // I-cache read, memory answers after 4 cycles
    bus.i_read = 1'b1; bus.i_addr = 28'h0000010;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("i1_mem_read", 128'(bus.mem_read), 128'(1));
      check("i1_mem_addr", 128'(bus.mem_addr), 128'(28'h10));
      check("i1_i_ready",  128'(bus.i_ready),  128'(0));
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = pat_a5;
    tick();
    check("i1_done_i_ready",  128'(bus.i_ready),  128'(1));
    check("i1_done_d_ready",  128'(bus.d_ready),  128'(0));
    check("i1_done_i_rdata",  bus.i_rdata,        pat_a5);
    check("i1_done_mem_read", 128'(bus.mem_read), 128'(0));
    bus.mem_ready = 1'b0; bus.i_read = 1'b0;
    tick();
    check("i1_idle_i_ready", 128'(bus.i_ready), 128'(0));
    check("i1_idle_i_rdata", bus.i_rdata,       pat_a5);

    // D-cache write; later address change must be ignored
    bus.d_write = 1'b1; bus.d_addr = 28'h20; bus.d_wdata = 128'h1234;
    tick();
    check("dw_mem_write", 128'(bus.mem_write), 128'(1));
    check("dw_mem_read",  128'(bus.mem_read),  128'(0));
    check("dw_mem_addr",  128'(bus.mem_addr),  128'(28'h20));
    check("dw_mem_wdata", bus.mem_wdata,       128'h1234);
    bus.d_addr = 28'h99; bus.d_wdata = 128'h9999;
    tick();
    check("dw_hold_addr",  128'(bus.mem_addr), 128'(28'h20));
    check("dw_hold_wdata", bus.mem_wdata,      128'h1234);
    check("dw_hold_read",  128'(bus.mem_read), 128'(0));
    // mem_ready held three cycles: one completion only
    bus.mem_ready = 1'b1; bus.mem_rdata = 128'hDEAD;
    tick();
    check("dw_done_d_ready",   128'(bus.d_ready),   128'(1));
    check("dw_done_i_ready",   128'(bus.i_ready),   128'(0));
    check("dw_done_d_rdata",   bus.d_rdata,         128'(0));
    check("dw_done_mem_write", 128'(bus.mem_write), 128'(0));
    bus.d_write = 1'b0;
    tick();
    check("mr_held_d_ready", 128'(bus.d_ready), 128'(0));
    tick();
    check("mr_idle_d_ready",  128'(bus.d_ready),  128'(0));
    check("mr_idle_i_ready",  128'(bus.i_ready),  128'(0));
    check("mr_idle_mem_read", 128'(bus.mem_read), 128'(0));
    bus.mem_ready = 1'b0;
    tick();
    // lone mem_ready pulse in IDLE
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("mr_pulse_i_ready", 128'(bus.i_ready), 128'(0));
    check("mr_pulse_d_ready", 128'(bus.d_ready), 128'(0));
    check("mr_pulse_d_rdata", bus.d_rdata,       128'(0));

    // Both reading continuously: I, D, I, D (last grant was D)
    bus.i_read = 1'b1; bus.i_addr = 28'h100;
    bus.d_read = 1'b1; bus.d_addr = 28'h200;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("rr_mem_read", 128'(bus.mem_read), 128'(1));
      check("rr_mem_addr", 128'(bus.mem_addr), (g % 2 == 0) ? 128'(28'h100) : 128'(28'h200));
      bus.mem_ready = 1'b1; bus.mem_rdata = 128'(g + 1);
      tick();
      bus.mem_ready = 1'b0;
      check("rr_i_ready", 128'(bus.i_ready), (g % 2 == 0) ? 128'(1) : 128'(0));
      check("rr_d_ready", 128'(bus.d_ready), (g % 2 == 0) ? 128'(0) : 128'(1));
      check("rr_i_rdata", bus.i_rdata, (g < 2) ? 128'(1) : 128'(3));
      check("rr_d_rdata", bus.d_rdata, (g < 1) ? 128'(0) : ((g < 3) ? 128'(2) : 128'(4)));
      tick();
      check("rr_done_mem_read", 128'(bus.mem_read), 128'(0));
      check("rr_done_ready",    128'({bus.i_ready, bus.d_ready}), 128'(0));
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    tick();

    // Reset during D_BUSY abandons the write
    bus.d_write = 1'b1; bus.d_addr = 28'h30; bus.d_wdata = 128'h55;
    tick();
    check("rs_mem_write", 128'(bus.mem_write), 128'(1));
    bus.d_write = 1'b0;
    tick();
    check("rs_drop_mem_write", 128'(bus.mem_write), 128'(1));
    rst = 1'b0;
    tick();
    check("rs_mem_write_clr", 128'(bus.mem_write), 128'(0));
    check("rs_mem_addr_clr",  128'(bus.mem_addr),  128'(0));
    check("rs_d_ready",       128'(bus.d_ready),   128'(0));
    rst = 1'b1;
    tick();
    check("rs_after_d_ready", 128'(bus.d_ready), 128'(0));
    bus.i_read = 1'b1; bus.d_read = 1'b1;
    tick();
    check("rs_tie_mem_addr", 128'(bus.mem_addr), 128'(28'h100));
    check("rs_tie_mem_read", 128'(bus.mem_read), 128'(1));
    // requests dropped mid-transaction still complete
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 128'hBEEF;
    tick();
    bus.mem_ready = 1'b0;
    check("rs_drop_i_ready", 128'(bus.i_ready), 128'(1));
    check("rs_drop_i_rdata", bus.i_rdata,       128'hBEEF);
    tick();

    // d_read together with d_write is a write
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 28'h40; bus.d_wdata = 128'h77;
    tick();
    check("rw_mem_write", 128'(bus.mem_write), 128'(1));
    check("rw_mem_read",  128'(bus.mem_read),  128'(0));
    check("rw_mem_wdata", bus.mem_wdata,       128'h77);
    bus.mem_ready = 1'b1; bus.mem_rdata = 128'hFFFF;
    tick();
    bus.mem_ready = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    check("rw_d_ready", 128'(bus.d_ready), 128'(1));
    check("rw_d_rdata", bus.d_rdata,       128'(0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
